// File: rtl/nanov_spi_fetch.sv
// SPI NOR instruction fetcher: sends a read command plus address, then streams
// little-endian 32-bit words to a consumer, pausing the SPI clock while it stalls.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, SPI idle, waiting for the first start
// CMD    | shifting READ_CMD out on spi_mosi
// ADDR   | shifting the fetch address out on spi_mosi
// DATA   | shifting instruction bits in from spi_miso (continuous read)
// STALL  | completed word buffered, consumer busy, spi_clk_out held low
// DESEL  | two-cycle chip-select release before a restarted command
module nanov_spi_fetch #(
    parameter int         ADDR_BITS = 24,
    parameter logic [7:0] READ_CMD  = 8'h03
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic                 next,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic [ADDR_BITS-1:0] instr_addr,
    output logic                 busy,
    output logic                 spi_select,
    output logic                 spi_clk_out,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int MAXB = (ADDR_BITS > 32) ? ADDR_BITS : 32;
    localparam int CW   = $clog2(MAXB);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_STALL, S_DESEL
    } state_t;

    state_t                state, state_nxt;
    logic                  phase;
    logic [CW-1:0]         bit_left;
    logic                  desel_cnt;
    logic [ADDR_BITS-1:0]  fetch_addr;
    logic [31:0]           shreg;
    logic [31:0]           sh_next;
    logic [31:0]           word_buf;
    logic                  pend;
    logic                  shifting;
    logic                  bit_end;
    logic                  word_done;
    logic                  xfer;

    assign shifting  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    assign bit_end   = shifting && phase && (bit_left == '0);
    assign word_done = (state == S_DATA) && bit_end;
    assign sh_next   = {shreg[30:0], spi_miso};

    // The transfer decision is taken one cycle after the last bit, during the
    // low phase of the next word's first bit; STALL then parks before its high phase.
    assign xfer = !start && pend &&
                  (((state == S_DATA) && (!instr_valid || next)) ||
                   ((state == S_STALL) && next));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = (state == S_IDLE) ? S_CMD : S_DESEL;
        end else begin
            case (state)
                S_CMD:   if (bit_end) state_nxt = S_ADDR;
                S_ADDR:  if (bit_end) state_nxt = S_DATA;
                S_DATA:  if (pend && !xfer) state_nxt = S_STALL;
                S_STALL: if (next) state_nxt = S_DATA;
                S_DESEL: if (desel_cnt == 1'b0) state_nxt = S_CMD;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy        = (state != S_IDLE);
        spi_select  = !(shifting || (state == S_STALL));
        spi_clk_out = shifting && phase;
        spi_mosi    = 1'b0;
        case (state)
            S_CMD:   spi_mosi = READ_CMD[bit_left[2:0]];
            S_ADDR:  spi_mosi = fetch_addr[bit_left];
            default: spi_mosi = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase       <= 1'b0;
            bit_left    <= '0;
            desel_cnt   <= 1'b0;
            fetch_addr  <= '0;
            shreg       <= '0;
            word_buf    <= '0;
            pend        <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            instr_addr  <= '0;
        end else if (start) begin
            fetch_addr  <= {start_addr[ADDR_BITS-1:2], 2'b00};
            instr_valid <= 1'b0;
            pend        <= 1'b0;
            phase       <= 1'b0;
            bit_left    <= CW'(7);
            desel_cnt   <= 1'b1;
        end else begin
            case (state)
                S_CMD, S_ADDR, S_DATA: begin
                    phase <= ~phase;
                    if (phase) begin
                        if (bit_left != '0)
                            bit_left <= bit_left - 1'b1;
                        else if (state == S_CMD)
                            bit_left <= CW'(ADDR_BITS - 1);
                        else
                            bit_left <= CW'(31);
                    end
                    if ((state == S_DATA) && phase)
                        shreg <= sh_next;
                    // first byte on the wire is the least significant byte
                    if (word_done) begin
                        word_buf <= {sh_next[7:0], sh_next[15:8],
                                     sh_next[23:16], sh_next[31:24]};
                        pend     <= 1'b1;
                    end
                end
                S_DESEL: desel_cnt <= 1'b0;
                default: ;
            endcase
            if (xfer) begin
                instr       <= word_buf;
                instr_addr  <= fetch_addr;
                fetch_addr  <= fetch_addr + ADDR_BITS'(4);
                instr_valid <= 1'b1;
                pend        <= 1'b0;
            end else if (next && instr_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
